writeback_regfile: RTL and testbench
====================================

// Module: writeback_regfile
// PURPOSE
//  Writeback stage of the 5-stage RV32I pipeline, merged with the architectural register file.
//  It consumes the MEM/WB pipeline register outputs and selects the writeback result.
//  It commits that result to x1..x31 and serves the two decode-stage read ports with write-first bypass.
//  It also keeps a 64-bit retired-instruction counter and exports the result for the hazard/forwarding unit.
// PARAMETERS
//  DATA_WIDTH      32  datapath / register width
//  REGISTER_WIDTH  5   register index width; register count = 2**REGISTER_WIDTH
//  CNT_WIDTH       64  retired-instruction counter width
// PORTS
//  clk             in   1               clock; all state updates on rising edge
//  rst             in   1               synchronous reset, active-high
//  alu_result_w_i  in   DATA_WIDTH      ALU result from MEM/WB register
//  read_data_w_i   in   DATA_WIDTH      load data from MEM/WB register
//  pc_plus4_w_i    in   DATA_WIDTH      PC+4 from MEM/WB register (JAL/JALR link)
//  imm_ext_w_i     in   DATA_WIDTH      extended immediate from MEM/WB register (LUI)
//  rd_w_i          in   REGISTER_WIDTH  destination register index
//  result_src_w_i  in   2               result select: 00 ALU, 01 load, 10 PC+4, 11 imm
//  reg_write_w_i   in   1               commit enable for rd_w_i
//  valid_w_i       in   1               1 = real instruction in WB; 0 = bubble/flushed slot
//  rs1_d_i         in   REGISTER_WIDTH  decode-stage source index 1
//  rs2_d_i         in   REGISTER_WIDTH  decode-stage source index 2
//  rd1_d_o         out  DATA_WIDTH      value of rs1_d_i (combinational)
//  rd2_d_o         out  DATA_WIDTH      value of rs2_d_i (combinational)
//  result_w_o      out  DATA_WIDTH      selected writeback result (combinational, to forwarding muxes)
//  instret_o       out  CNT_WIDTH       count of retired instructions (registered)
//  a0_o            out  DATA_WIDTH      current contents of x10 (registered value, debug/test)
// BEHAVIOUR
//  - Result mux (combinational):
//    - result_w_o = alu / read_data / pc_plus4 / imm per result_src_w_i.
//    - No registered latency through WB.
//  - Commit condition: valid_w_i && reg_write_w_i && rd_w_i!=0.
//    - When true, regs[rd_w_i] <= result_w_o on the rising edge.
//  - x0:
//    - Never written; it reads 0 regardless of writes.
//    - A write to rd=0 is a no-op, but it still counts toward instret when valid.
//  - Read ports (combinational), write-first bypass:
//    - If the commit condition holds and rs1_d_i==rd_w_i, rd1_d_o = result_w_o.
//    - Otherwise rd1_d_o = regs[rs1_d_i]. rd2_d_o follows the same rule.
//    - Decode therefore sees a same-cycle WB write, with no extra hazard stall.
//  - Bypass applies only to the current WB instruction.
//    - Qualified by valid_w_i: a bubble with stale reg_write_w_i=1 neither writes nor bypasses.
//  - instret:
//    - instret_o <= instret_o + 1 when valid_w_i, independent of reg_write_w_i (stores/branches count).
//    - Wraps modulo 2**CNT_WIDTH: all-ones + 1 -> 0, with no flag.
//  - Reset (rst=1 at a rising edge):
//    - All regs cleared to 0 and instret_o cleared to 0. a0_o reads 0.
//    - Reset has priority: any commit presented in the same cycle is dropped and not counted.
//    - While rst is held, rd1/rd2 still bypass combinationally if the commit condition holds.
//    - The stored write is still dropped.
//  - After reset deasserts, the first valid commit lands on the next rising edge.
//  - No internal stall input: the upstream pipeline register holds values. A held valid slot is counted each cycle.
//    - Upstream must therefore drive valid_w_i=0 on a repeated (stalled) slot.
// TESTING
//  1. Reset: regs pre-written, then rst=1 for one edge.
//     -> read rs1=5, rs2=31 gives 0/0; instret_o=0; a0_o=0.
//  2. Result mux: alu=0x11, load=0x22, pc4=0x33, imm=0x44, rd=10, src 00..11 over 4 valid cycles.
//     -> a0_o 0x11, 0x22, 0x33, 0x44 in turn; instret_o=4.
//  3. x0 guard: rd=0, src=00, alu=0xDEADBEEF, reg_write=1, valid=1, rs1=0.
//     -> rd1_d_o=0 in that cycle and after; instret_o increments by 1.
//  4. Bypass: x7=0x5; commit rd=7, alu=0x9 with rs1=rs2=7 in the same cycle.
//     -> rd1=rd2=0x9 combinationally; with valid=0 instead, rd1=rd2=0x5 and x7 stays 0x5.
//  5. Reset priority: commit rd=3, alu=0x77, valid=1 with rst=1 in the same cycle.
//     -> x3=0 after the edge; instret_o=0.
//  6. Counter wrap (CNT_WIDTH=4 build): 16 valid cycles then 1 more.
//     -> instret_o reads 15 then 0, then 1.

Source files
------------

// File: rtl/writeback_regfile.sv
// RV32I writeback stage fused with the x0..x31 register file; result and read ports are combinational, commits and instret update on the clock edge.
// No stall input and no backpressure: every valid slot presented is consumed (and counted) on each rising edge.
module writeback_regfile #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_WIDTH = 5,
    parameter int CNT_WIDTH      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     alu_result_w_i,
    input  logic [DATA_WIDTH-1:0]     read_data_w_i,
    input  logic [DATA_WIDTH-1:0]     pc_plus4_w_i,
    input  logic [DATA_WIDTH-1:0]     imm_ext_w_i,
    input  logic [REGISTER_WIDTH-1:0] rd_w_i,
    input  logic [1:0]                result_src_w_i,
    input  logic                      reg_write_w_i,
    input  logic                      valid_w_i,
    input  logic [REGISTER_WIDTH-1:0] rs1_d_i,
    input  logic [REGISTER_WIDTH-1:0] rs2_d_i,
    output logic [DATA_WIDTH-1:0]     rd1_d_o,
    output logic [DATA_WIDTH-1:0]     rd2_d_o,
    output logic [DATA_WIDTH-1:0]     result_w_o,
    output logic [CNT_WIDTH-1:0]      instret_o,
    output logic [DATA_WIDTH-1:0]     a0_o
);

    localparam int NUM_REGS = 2 ** REGISTER_WIDTH;
    localparam logic [REGISTER_WIDTH-1:0] A0_IDX = REGISTER_WIDTH'(10);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  commit;

    always_comb begin
        result_w_o = alu_result_w_i;
        case (result_src_w_i)
            2'b00:   result_w_o = alu_result_w_i;
            2'b01:   result_w_o = read_data_w_i;
            2'b10:   result_w_o = pc_plus4_w_i;
            default: result_w_o = imm_ext_w_i;
        endcase
    end

    assign commit = valid_w_i && reg_write_w_i && (rd_w_i != '0);

    // Write-first bypass: decode sees this cycle's commit; x0 can never match since commit excludes rd=0.
    always_comb begin
        rd1_d_o = '0;
        rd2_d_o = '0;
        if (commit && rs1_d_i == rd_w_i)
            rd1_d_o = result_w_o;
        else if (rs1_d_i != '0)
            rd1_d_o = regs[rs1_d_i];
        if (commit && rs2_d_i == rd_w_i)
            rd2_d_o = result_w_o;
        else if (rs2_d_i != '0)
            rd2_d_o = regs[rs2_d_i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (commit) begin
            regs[rd_w_i] <= result_w_o;
        end
    end

    // Retires every valid slot, stores and branches included; wraps silently.
    always_ff @(posedge clk) begin
        if (rst)
            instret_o <= '0;
        else if (valid_w_i)
            instret_o <= instret_o + CNT_WIDTH'(1);
    end

    assign a0_o = regs[A0_IDX];

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: default build plus a 4-bit instret build for the wrap case.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst, rst4, valid4;
    logic [31:0] alu, ld, pc4, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  src;
    logic        rw, valid;
    logic [31:0] rd1, rd2, res, a0;
    logic [63:0] instret;
    logic [31:0] rd1_4, rd2_4, res_4, a0_4;
    logic [3:0]  instret4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk(clk), .rst(rst),
        .alu_result_w_i(alu), .read_data_w_i(ld), .pc_plus4_w_i(pc4), .imm_ext_w_i(imm),
        .rd_w_i(rd), .result_src_w_i(src), .reg_write_w_i(rw), .valid_w_i(valid),
        .rs1_d_i(rs1), .rs2_d_i(rs2),
        .rd1_d_o(rd1), .rd2_d_o(rd2), .result_w_o(res), .instret_o(instret), .a0_o(a0)
    );

    writeback_regfile #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4),
        .alu_result_w_i(alu), .read_data_w_i(ld), .pc_plus4_w_i(pc4), .imm_ext_w_i(imm),
        .rd_w_i(rd), .result_src_w_i(src), .reg_write_w_i(rw), .valid_w_i(valid4),
        .rs1_d_i(rs1), .rs2_d_i(rs2),
        .rd1_d_o(rd1_4), .rd2_d_o(rd2_4), .result_w_o(res_4), .instret_o(instret4), .a0_o(a0_4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit_alu(input logic [4:0] dst, input logic [31:0] val);
        rd = dst; alu = val; src = 2'b00; rw = 1'b1; valid = 1'b1;
        tick();
        valid = 1'b0; rw = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rst4 = 1'b1; valid4 = 1'b0;
        alu = '0; ld = '0; pc4 = '0; imm = '0;
        rd = '0; rs1 = '0; rs2 = '0; src = '0; rw = 1'b0; valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("init_instret", instret, 64'd0);

        // Reset clears pre-written registers
        commit_alu(5'd5, 32'hAAAA);
        commit_alu(5'd31, 32'hBBBB);
        commit_alu(5'd10, 32'hCCCC);
        rs1 = 5'd5; rs2 = 5'd31; #1;
        check("prewrite_x5", rd1, 64'hAAAA);
        check("prewrite_x31", rd2, 64'hBBBB);
        check("prewrite_instret", instret, 64'd3);
        rst = 1'b1; tick(); rst = 1'b0; #1;
        check("reset_rd1", rd1, 64'd0);
        check("reset_rd2", rd2, 64'd0);
        check("reset_instret", instret, 64'd0);
        check("reset_a0", a0, 64'd0);

        // Result mux, all four sources into x10
        alu = 32'h11; ld = 32'h22; pc4 = 32'h33; imm = 32'h44;
        rd = 5'd10; rw = 1'b1; valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            src = 2'(s); #1;
            check("mux_result", res, 64'h11 * (s + 1));
            tick();
            check("mux_a0", a0, 64'h11 * (s + 1));
        end
        valid = 1'b0; rw = 1'b0; src = 2'b00; #1;
        check("mux_instret", instret, 64'd4);

        // x0 is never written but the slot still retires
        rd = 5'd0; alu = 32'hDEADBEEF; rw = 1'b1; valid = 1'b1; rs1 = 5'd0; #1;
        check("x0_same_cycle", rd1, 64'd0);
        tick();
        valid = 1'b0; rw = 1'b0; #1;
        check("x0_after", rd1, 64'd0);
        check("x0_instret", instret, 64'd5);

        // Write-first bypass, and no bypass for a bubble
        commit_alu(5'd7, 32'h5);
        rd = 5'd7; alu = 32'h9; rw = 1'b1; valid = 1'b1; rs1 = 5'd7; rs2 = 5'd7; #1;
        check("bypass_rd1", rd1, 64'h9);
        check("bypass_rd2", rd2, 64'h9);
        valid = 1'b0; #1;
        check("bubble_rd1", rd1, 64'h5);
        check("bubble_rd2", rd2, 64'h5);
        tick();
        rw = 1'b0;
        check("bubble_x7_kept", rd1, 64'h5);
        check("bubble_instret", instret, 64'd6);

        // Reset beats a same-cycle commit, but the bypass is still visible
        rd = 5'd3; alu = 32'h77; rw = 1'b1; valid = 1'b1; rst = 1'b1; rs1 = 5'd3; #1;
        check("rstprio_bypass", rd1, 64'h77);
        tick();
        rst = 1'b0; valid = 1'b0; rw = 1'b0; #1;
        check("rstprio_x3", rd1, 64'd0);
        check("rstprio_instret", instret, 64'd0);
        check("rstprio_x7", rd2, 64'd0);

        // First commit after reset lands on the next edge
        commit_alu(5'd3, 32'h12);
        check("post_reset_x3", rd1, 64'h12);
        check("post_reset_instret", instret, 64'd1);

        // 4-bit counter wraps silently
        rst4 = 1'b0; valid4 = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("wrap_15", 64'(instret4), 64'd15);
        tick();
        check("wrap_0", 64'(instret4), 64'd0);
        tick();
        check("wrap_1", 64'(instret4), 64'd1);
        valid4 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
